// File: rtl/msx_io_pkg.sv
// Shared definitions for the MSX mouse port bridge.
//   phase_t        : nibble sequence position (X high, X low, Y high, Y low)
//   *_BIT / *_MSB  : field positions inside the hps_io ps2_mouse bus
//   clamp8         : clamp a signed count into the 8-bit range sent to the MSX
//   sat_add        : signed add saturating to a w-bit two's complement range
package msx_io_pkg;

  typedef enum logic [1:0] {PH_XH, PH_XL, PH_YH, PH_YL} phase_t;

  localparam int PKT_TOG_BIT = 24;
  localparam int DY_MSB      = 23;
  localparam int DY_LSB      = 16;
  localparam int DX_MSB      = 15;
  localparam int DX_LSB      = 8;
  localparam int BTN_L_BIT   = 0;
  localparam int BTN_R_BIT   = 1;
  localparam int X_SIGN_BIT  = 4;
  localparam int Y_SIGN_BIT  = 5;

  function automatic logic signed [7:0] clamp8(input int v);
    logic signed [7:0] r;
    if (v > 127)
      r = 8'sd127;
    else if (v < -128)
      r = -8'sd128;
    else
      r = v[7:0];
    return r;
  endfunction

  function automatic int sat_add(input int a, input int b, input int w);
    int s;
    int hi;
    int lo;
    s  = a + b;
    hi = (1 << (w - 1)) - 1;
    lo = -(1 << (w - 1));
    if (s > hi)
      s = hi;
    else if (s < lo)
      s = lo;
    return s;
  endfunction

endpackage

// File: rtl/mouse_motion_acc.sv
// One axis of relative-motion accumulation.
//   clk_sys, reset_n : clock and synchronous active-low reset
//   add_en, delta    : packet strobe and signed per-packet motion
//   latch_en         : take a snapshot for transmission this cycle
//   acc              : saturating signed accumulator
//   latched          : snapshot sent to the host (clamped to 8 bits)
//   clamp_now        : combinational clamp of acc, valid in the latch cycle
module mouse_motion_acc
  import msx_io_pkg::*;
#(
  parameter int ACC_W = 12
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic                    add_en,
  input  logic signed [9:0]       delta,
  input  logic                    latch_en,
  output logic signed [ACC_W-1:0] acc,
  output logic signed [7:0]       latched,
  output logic signed [7:0]       clamp_now
);

  int                    base;
  int                    addend;
  logic signed [ACC_W-1:0] acc_next;

  always_comb begin
    clamp_now = clamp8(int'(acc));
  end

  // The snapshot is removed from the pre-packet value, so a packet arriving
  // in the latch cycle lands entirely in the residue rather than being lost.
  always_comb begin
    addend   = add_en ? int'(delta) : 0;
    base     = latch_en ? (int'(acc) - int'(clamp_now)) : int'(acc);
    acc_next = ACC_W'(sat_add(base, addend, ACC_W));
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      acc     <= '0;
      latched <= '0;
    end else begin
      if (latch_en || add_en)
        acc <= acc_next;
      if (latch_en)
        latched <= clamp_now;
    end
  end

endmodule

// File: rtl/msx_mouse_port.sv
// PS/2 mouse (hps_io ps2_mouse bus) to MSX joystick-port mouse protocol.
//   clk_sys   : system clock, single domain
//   reset_n   : synchronous active-low reset
//   ps2_mouse : [24] packet toggle, [23:16] dy, [15:8] dx, [7:0] status
//   strobe    : port pin 8; every edge advances the nibble sequence
//   data      : [5] ~right, [4] ~left, [3:0] current nibble
//
// phase | meaning
// ------+---------------------------------------------------------------
// PH_XH | next strobe edge latches X/Y and shows X[7:4]
// PH_XL | next strobe edge shows X[3:0]
// PH_YH | next strobe edge shows Y[7:4]
// PH_YL | next strobe edge shows Y[3:0]
// A strobe gap longer than the timeout returns the phase to PH_XH.
module msx_mouse_port
  import msx_io_pkg::*;
#(
  parameter int CLK_HZ     = 21477270,
  parameter int TIMEOUT_US = 1500,
  parameter int ACC_W      = 12
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [24:0] ps2_mouse,
  input  logic        strobe,
  output logic [5:0]  data
);

  // 64-bit product: the default CLK_HZ*TIMEOUT_US does not fit in 32 bits.
  localparam longint TIMEOUT_L   = longint'(CLK_HZ) * longint'(TIMEOUT_US) / 64'd1000000;
  localparam int     TIMEOUT_CYC = int'(TIMEOUT_L);
  localparam int     CNT_W       = $clog2(TIMEOUT_CYC + 1);

  logic              pkt_q;
  logic              stb_q;
  logic              pkt;
  logic              stb;
  logic              trip;
  logic              latch_en;
  logic signed [8:0] dx9;
  logic signed [8:0] dy9;
  logic signed [9:0] delta_x;
  logic signed [9:0] delta_y;
  logic [CNT_W-1:0]  cnt;
  phase_t            phase;

  logic signed [ACC_W-1:0] acc_x;
  logic signed [ACC_W-1:0] acc_y;
  logic signed [7:0]       lat_x;
  logic signed [7:0]       lat_y;
  logic signed [7:0]       now_x;
  logic signed [7:0]       now_y;

  always_comb begin
    pkt      = ps2_mouse[PKT_TOG_BIT] ^ pkt_q;
    stb      = strobe ^ stb_q;
    trip     = (cnt == CNT_W'(TIMEOUT_CYC));
    latch_en = stb && (phase == PH_XH);
    dx9      = {ps2_mouse[X_SIGN_BIT], ps2_mouse[DX_MSB:DX_LSB]};
    dy9      = {ps2_mouse[Y_SIGN_BIT], ps2_mouse[DY_MSB:DY_LSB]};
    // MSX X is positive-left, PS/2 X is positive-right.
    delta_x  = -{dx9[8], dx9};
    delta_y  = {dy9[8], dy9};
  end

  mouse_motion_acc #(.ACC_W(ACC_W)) u_acc_x (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .add_en    (pkt),
    .delta     (delta_x),
    .latch_en  (latch_en),
    .acc       (acc_x),
    .latched   (lat_x),
    .clamp_now (now_x)
  );

  mouse_motion_acc #(.ACC_W(ACC_W)) u_acc_y (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .add_en    (pkt),
    .delta     (delta_y),
    .latch_en  (latch_en),
    .acc       (acc_y),
    .latched   (lat_y),
    .clamp_now (now_y)
  );

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      // History follows the inputs so releasing reset never looks like an edge.
      pkt_q <= ps2_mouse[PKT_TOG_BIT];
      stb_q <= strobe;
      phase <= PH_XH;
      cnt   <= '0;
      data  <= 6'b110000;
    end else begin
      pkt_q <= ps2_mouse[PKT_TOG_BIT];
      stb_q <= strobe;

      if (pkt)
        data[5:4] <= ~{ps2_mouse[BTN_R_BIT], ps2_mouse[BTN_L_BIT]};

      // A strobe edge in the trip cycle wins and uses the pre-trip phase.
      if (stb) begin
        cnt <= '0;
        case (phase)
          PH_XH: begin
            data[3:0] <= now_x[7:4];
            phase     <= PH_XL;
          end
          PH_XL: begin
            data[3:0] <= lat_x[3:0];
            phase     <= PH_YH;
          end
          PH_YH: begin
            data[3:0] <= lat_y[7:4];
            phase     <= PH_YL;
          end
          PH_YL: begin
            data[3:0] <= lat_y[3:0];
            phase     <= PH_XH;
          end
          default: phase <= PH_XH;
        endcase
      end else if (trip) begin
        phase <= PH_XH;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // acc_x/acc_y are exposed for observation only.
  logic unused_acc;
  always_comb unused_acc = ^{acc_x, acc_y};

endmodule

// File: tb/tb_msx_mouse_port.sv
// Bench for msx_mouse_port: a motion/phase model tracked per stimulus step,
// compared against the DUT on every falling clock edge, plus literal
// nibble/button expectations from hand calculation.
module tb_msx_mouse_port;

  localparam int CLK_HZ     = 1000000;
  localparam int TIMEOUT_US = 200;
  localparam int T_CYC      = 200;
  localparam int ACC_MAX    = 2047;
  localparam int ACC_MIN    = -2048;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [24:0] ps2_mouse;
  logic        strobe;
  logic [5:0]  data;

  msx_mouse_port #(
    .CLK_HZ     (CLK_HZ),
    .TIMEOUT_US (TIMEOUT_US),
    .ACC_W      (12)
  ) dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .ps2_mouse (ps2_mouse),
    .strobe    (strobe),
    .data      (data)
  );

  always #5 clk_sys = ~clk_sys;

  // model state
  int         m_ax, m_ay, m_lx, m_ly, m_ph, m_gap;
  logic [5:0] exp_data;

  // checking state (counters written only by the compare process)
  int         n_checks = 0;
  int         n_errors = 0;
  bit         chk_on   = 0;
  int         lit_seq  = 0;
  int         lit_done = 0;
  string      lit_name;
  logic [5:0] lit_mask;
  logic [5:0] lit_exp;

  function automatic int msat(input int v);
    if (v > ACC_MAX) return ACC_MAX;
    if (v < ACC_MIN) return ACC_MIN;
    return v;
  endfunction

  function automatic int mclamp(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  function automatic logic [24:0] mk(input logic tog, input int dx, input int dy,
                                     input logic l, input logic r);
    logic [8:0] x9;
    logic [8:0] y9;
    x9 = dx[8:0];
    y9 = dy[8:0];
    return {tog, y9[7:0], x9[7:0], 2'b00, y9[8], x9[8], 2'b00, r, l};
  endfunction

  task automatic model_reset();
    m_ax = 0; m_ay = 0; m_lx = 0; m_ly = 0; m_ph = 0; m_gap = 0;
    exp_data = 6'b110000;
  endtask

  task automatic model_toggle();
    int v;
    if (m_gap > T_CYC) m_ph = 0;
    case (m_ph)
      0: begin
        m_lx = mclamp(m_ax);
        m_ly = mclamp(m_ay);
        m_ax = m_ax - m_lx;
        m_ay = m_ay - m_ly;
        v = (m_lx & 255) >> 4;
      end
      1: v = m_lx & 15;
      2: v = (m_ly & 255) >> 4;
      default: v = m_ly & 15;
    endcase
    exp_data[3:0] = v[3:0];
    m_ph  = (m_ph + 1) % 4;
    m_gap = 0;
  endtask

  task automatic model_packet(input int dx, input int dy, input logic l, input logic r);
    m_ax = msat(m_ax - dx);
    m_ay = msat(m_ay + dy);
    exp_data[5:4] = {~r, ~l};
  endtask

  // One clock of stimulus; a toggle coinciding with a packet is latched first.
  task automatic step(input bit t, input bit p, input int dx, input int dy,
                      input logic l, input logic r);
    if (t) strobe = ~strobe;
    if (p) ps2_mouse = mk(~ps2_mouse[24], dx, dy, l, r);
    @(posedge clk_sys);
    #1;
    if (t) model_toggle();
    else m_gap++;
    if (p) model_packet(dx, dy, l, r);
  endtask

  task automatic tog();
    step(1, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic pkt(input int dx, input int dy);
    step(0, 1, dx, dy, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic lit(input string nm, input logic [5:0] mask, input logic [5:0] ex);
    lit_name = nm;
    lit_mask = mask;
    lit_exp  = ex;
    lit_seq++;
  endtask

  task automatic lit_nib(input string nm, input logic [3:0] n);
    lit(nm, 6'h0F, {2'b00, n});
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk_sys);
    #1;
    model_reset();
    reset_n = 1'b1;
  endtask

  initial begin
    forever begin
      @(negedge clk_sys);
      if (chk_on) begin
        n_checks++;
        if (data !== exp_data) begin
          n_errors++;
          $display("FAIL model_cmp t=%0t data=%b expected=%b", $time, data, exp_data);
        end
        if (lit_seq != lit_done) begin
          lit_done = lit_seq;
          n_checks++;
          if ((data & lit_mask) !== lit_exp) begin
            n_errors++;
            $display("FAIL %s data=%b required=%b (mask %b)", lit_name, data & lit_mask,
                     lit_exp, lit_mask);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired before end of stimulus");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    strobe    = 1'b1;
    ps2_mouse = mk(1'b1, 0, 0, 1'b0, 1'b0);
    model_reset();
    do_reset();
    chk_on = 1;
    lit("reset_data", 6'h3F, 6'b110000);
    idle(2);

    // first toggle after reset: X high of zero motion
    tog();  lit_nib("rst_x_hi", 4'h0);
    tog();  tog();  tog();

    // dx=+5, dy=+3 -> X=-5 (0xFB), Y=0x03
    pkt(5, 3);
    tog();  lit_nib("p1_x_hi", 4'hF);
    tog();  lit_nib("p1_x_lo", 4'hB);
    tog();  lit_nib("p1_y_hi", 4'h0);
    tog();  lit_nib("p1_y_lo", 4'h3);

    // accX=+300 drains as 127, 127, 46
    pkt(-100, 0); pkt(-100, 0); pkt(-100, 0);
    tog();  lit_nib("big1_x_hi", 4'h7);
    tog();  lit_nib("big1_x_lo", 4'hF);
    tog();  tog();
    tog();  lit_nib("big2_x_hi", 4'h7);
    tog();  tog();  tog();
    tog();  lit_nib("big3_x_hi", 4'h2);
    tog();  lit_nib("big3_x_lo", 4'hE);
    tog();  tog();

    // buttons follow packets one cycle later, no strobe needed
    step(0, 1, 0, 0, 1'b1, 1'b0);  lit("btn_left", 6'h30, 6'b100000);
    step(0, 1, 0, 0, 1'b0, 1'b1);  lit("btn_right", 6'h30, 6'b010000);
    step(0, 1, 0, 0, 1'b0, 1'b0);  lit("btn_none", 6'h30, 6'b110000);

    // strobe gap beyond the timeout restarts at X high with a fresh latch
    pkt(-32, 80);
    tog();  lit_nib("to_x_hi", 4'h2);
    tog();
    idle(T_CYC + 5);
    pkt(-48, 0);
    tog();  lit_nib("to_restart_x_hi", 4'h3);
    tog();  tog();  tog();

    // gap just under the timeout keeps the sequence going
    pkt(-32, 80);
    tog();  tog();
    idle(T_CYC - 5);
    tog();  lit_nib("noto_y_hi", 4'h5);
    tog();

    // packet on the latch cycle: Lx=10, residue becomes +4
    pkt(-10, 0);
    step(1, 1, -4, 0, 1'b0, 1'b0);  lit_nib("sim_x_hi", 4'h0);
    tog();  lit_nib("sim_x_lo", 4'hA);
    tog();  tog();
    tog();  lit_nib("sim_res_x_hi", 4'h0);
    tog();  lit_nib("sim_res_x_lo", 4'h4);
    tog();  tog();

    // saturation: X pinned at +2047 then -2048 -> -1, Y pinned at -2048 then +2040 -> -8
    for (int i = 0; i < 9; i++) pkt(-255, 0);
    for (int i = 0; i < 16; i++) pkt(128, 0);
    for (int i = 0; i < 9; i++) pkt(0, -256);
    for (int i = 0; i < 8; i++) pkt(0, 255);
    tog();  lit_nib("sat_x_hi", 4'hF);
    tog();  lit_nib("sat_x_lo", 4'hF);
    tog();  lit_nib("sat_y_hi", 4'hF);
    tog();  lit_nib("sat_y_lo", 4'h8);

    // reset mid-sequence discards phase and pending motion
    pkt(-50, 0);
    tog();  lit_nib("pre_rst_x_hi", 4'h3);
    pkt(-20, 0);
    do_reset();
    lit("mid_rst_data", 6'h3F, 6'b110000);
    tog();  lit_nib("post_rst_x_hi", 4'h0);
    tog();  lit_nib("post_rst_x_lo", 4'h0);
    idle(2);

    @(negedge clk_sys);
    #1;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
